// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-request SRAM bus controller with fixed wait states for the LC-3 MAR/MDR path.
module mem_bus_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [15:0] Addr,
    input  logic [15:0] Wdata,
    output logic [15:0] Rdata,
    output logic        Ready,
    output logic        Busy,
    output logic [15:0] Mem_Addr,
    output logic [15:0] Mem_Dout,
    input  logic [15:0] Mem_Din,
    output logic        Mem_CE,
    output logic        Mem_OE,
    output logic        Mem_WE
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic we_q, accept, finish;
    logic [15:0] addr_q, wdata_q, rdata_q;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= WE;
                addr_q  <= Addr;
                wdata_q <= Wdata;
            end
            if (finish && !we_q) rdata_q <= Mem_Din;
        end
    end
    // The counter parks at zero on the last ACCESS cycle, so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (Req) begin
                accept    = 1'b1;
                cnt_nxt   = 4'(WAIT_CYCLES);
                state_nxt = ACCESS;
            end
            ACCESS: if (cnt == 4'd0) begin
                finish    = 1'b1;
                state_nxt = DONE;
            end else cnt_nxt = cnt - 4'd1;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    assign Ready    = state == DONE;
    assign Busy     = state != IDLE;
    assign Mem_CE   = state == ACCESS;
    assign Mem_OE   = Mem_CE & ~we_q;
    assign Mem_WE   = Mem_CE & we_q;
    assign Mem_Addr = addr_q;
    assign Mem_Dout = wdata_q;
    assign Rdata    = rdata_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed vector bench for mem_bus_ctrl with WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_mem_bus_ctrl;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, Req, WE;
    logic [15:0] Addr, Wdata, Rdata, Mem_Addr, Mem_Dout, Mem_Din;
    logic        Ready, Busy, Mem_CE, Mem_OE, Mem_WE;

    logic        z_reset, z_req, z_we;
    logic [15:0] z_addr, z_wdata, z_rdata, z_mem_addr, z_mem_dout, z_mem_din;
    logic        z_ready, z_busy, z_ce, z_oe, z_mwe;

    int errors = 0;
    int checks = 0;

    function automatic logic [15:0] model(input logic [15:0] a);
        return a == 16'h3000 ? 16'h1234 : a == 16'h0005 ? 16'h00FF : a ^ 16'hA5A5;
    endfunction

    assign Mem_Din   = model(Mem_Addr);
    assign z_mem_din = model(z_mem_addr);

    mem_bus_ctrl #(.WAIT_CYCLES(2)) u_w2 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .WE(WE), .Addr(Addr), .Wdata(Wdata),
        .Rdata(Rdata), .Ready(Ready), .Busy(Busy), .Mem_Addr(Mem_Addr), .Mem_Dout(Mem_Dout),
        .Mem_Din(Mem_Din), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    mem_bus_ctrl #(.WAIT_CYCLES(0)) u_w0 (
        .Clk(Clk), .Reset(z_reset), .Req(z_req), .WE(z_we), .Addr(z_addr), .Wdata(z_wdata),
        .Rdata(z_rdata), .Ready(z_ready), .Busy(z_busy), .Mem_Addr(z_mem_addr), .Mem_Dout(z_mem_dout),
        .Mem_Din(z_mem_din), .Mem_CE(z_ce), .Mem_OE(z_oe), .Mem_WE(z_mwe)
    );

    typedef struct {
        logic        rst, req, we;
        logic [15:0] addr, wdata;
        logic        rdy, bsy, ce, oe, mwe;
        logic [15:0] maddr, mdout, rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, req, we, input logic [15:0] addr, wdata,
                                input logic rdy, bsy, ce, oe, mwe,
                                input logic [15:0] maddr, mdout, rdata);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.rdy = rdy; v.bsy = bsy; v.ce = ce; v.oe = oe; v.mwe = mwe;
        v.maddr = maddr; v.mdout = mdout; v.rdata = rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_all(input string tag, input logic rdy, bsy, ce, oe, mwe,
                             input logic [15:0] maddr, rdata);
        check({tag, ".Ready"}, 16'(Ready), 16'(rdy));
        check({tag, ".Busy"}, 16'(Busy), 16'(bsy));
        check({tag, ".Mem_CE"}, 16'(Mem_CE), 16'(ce));
        check({tag, ".Mem_OE"}, 16'(Mem_OE), 16'(oe));
        check({tag, ".Mem_WE"}, 16'(Mem_WE), 16'(mwe));
        check({tag, ".Mem_Addr"}, Mem_Addr, maddr);
        check({tag, ".Rdata"}, Rdata, rdata);
    endtask

    initial begin
        Reset = 1'b1; Req = 1'b1; WE = 1'b0; Addr = 16'h3000; Wdata = 16'h0000;
        z_reset = 1'b1; z_req = 1'b0; z_we = 1'b0; z_addr = 16'h0000; z_wdata = 16'h0000;

        // reset held two cycles with Req high
        vecs.push_back(mk(1, 1, 0, 16'h3000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
        vecs.push_back(mk(1, 1, 0, 16'h3000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000));
        // read 0x3000, W=2: ACCESS cycles 1-3, Ready cycle 4, idle cycle 5
        vecs.push_back(mk(0, 1, 0, 16'h3000, 16'h0000, 0, 1, 1, 1, 0, 16'h3000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'h1111, 16'h2222, 0, 1, 1, 1, 0, 16'h3000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 16'h1111, 16'h2222, 0, 1, 1, 1, 0, 16'h3000, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 16'h3000, 16'h0000, 16'h1234));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h3000, 16'h0000, 16'h1234));
        // write 0x4001 <= 0xBEEF with Req held and inputs churning while busy
        vecs.push_back(mk(0, 1, 1, 16'h4001, 16'hBEEF, 0, 1, 1, 0, 1, 16'h4001, 16'hBEEF, 16'h1234));
        vecs.push_back(mk(0, 1, 0, 16'h7777, 16'h0000, 0, 1, 1, 0, 1, 16'h4001, 16'hBEEF, 16'h1234));
        vecs.push_back(mk(0, 1, 0, 16'h7777, 16'h0000, 0, 1, 1, 0, 1, 16'h4001, 16'hBEEF, 16'h1234));
        vecs.push_back(mk(0, 1, 0, 16'h7777, 16'h0000, 1, 1, 0, 0, 0, 16'h4001, 16'hBEEF, 16'h1234));
        vecs.push_back(mk(0, 1, 0, 16'h7777, 16'h0000, 0, 0, 0, 0, 0, 16'h4001, 16'hBEEF, 16'h1234));

        foreach (vecs[k]) begin
            Reset = vecs[k].rst; Req = vecs[k].req; WE = vecs[k].we;
            Addr = vecs[k].addr; Wdata = vecs[k].wdata;
            step();
            check_all($sformatf("vec%0d", k), vecs[k].rdy, vecs[k].bsy, vecs[k].ce, vecs[k].oe,
                      vecs[k].mwe, vecs[k].maddr, vecs[k].rdata);
            check($sformatf("vec%0d.Mem_Dout", k), Mem_Dout, vecs[k].mdout);
        end

        // back-to-back reads, address changes every cycle; accepts at edges 0,5,10
        Req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            logic [15:0] a;
            int p;
            Req = 1'b1; WE = 1'b0; Addr = 16'h5000 + 16'(i); Wdata = 16'h0000;
            step();
            a = 16'h5000 + 16'(5 * (i / 5));
            p = i % 5;
            check_all($sformatf("b2b%0d", i), p == 3, p != 4, p < 3, p < 3, 1'b0, a,
                      p >= 3 ? model(a) : (i < 5 ? 16'h1234 : model(a - 16'd5)));
        end

        // reset asserted in cycle 2 of a read
        Req = 1'b1; WE = 1'b0; Addr = 16'h3000;
        step();
        Req = 1'b0;
        step();
        check("rst_mid.cycle2_ce", 16'(Mem_CE), 16'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_all("rst_mid.c3", 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("rst_mid.c%0d", i + 4), 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
        end
        Req = 1'b1; Addr = 16'h0005;
        step();
        Req = 1'b0; Addr = 16'h0000;
        check_all("after_rst.c1", 0, 1, 1, 1, 0, 16'h0005, 16'h0000);
        step();
        step();
        step();
        check_all("after_rst.c4", 1, 1, 0, 0, 0, 16'h0005, 16'h00FF);

        // WAIT_CYCLES=0 instance: read 0x0005
        z_reset = 1'b0;
        check("w0.rdata_reset", z_rdata, 16'h0000);
        z_req = 1'b1; z_addr = 16'h0005;
        step();
        z_req = 1'b0; z_addr = 16'h0000;
        check("w0.c1.ce", 16'(z_ce), 16'd1);
        check("w0.c1.oe", 16'(z_oe), 16'd1);
        check("w0.c1.ready", 16'(z_ready), 16'd0);
        step();
        check("w0.c2.ready", 16'(z_ready), 16'd1);
        check("w0.c2.rdata", z_rdata, 16'h00FF);
        check("w0.c2.ce", 16'(z_ce), 16'd0);
        step();
        check("w0.c3.busy", 16'(z_busy), 16'd0);
        check("w0.c3.ready", 16'(z_ready), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
